// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline control blocks: PC source, operand
// forward selects and the interrupt-entry FSM states.
package cpu_ctrl_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [2:0] {
    IRQ_IDLE,
    IRQ_DEFER,
    IRQ_TAKE,
    IRQ_ENTER,
    IRQ_RUN
  } irq_state_e;

endpackage

// File: rtl/fwd_select.sv
// Picks the newest in-flight producer of one source register: MEM beats WB.
// Purely combinational; register 0 is hardwired and never forwarded.
module fwd_select
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwr,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwr,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != '0) begin
      if (mem_regwr && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_regwr && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, redirect, forwarding and interrupt-entry sequencing for the 5-stage pipe.
// Stall/flush/forward/exc_take are same-cycle combinational; irq_take is a registered 1-cycle strobe.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  input  logic             kernel_mode,
  input  logic             id_undef,
  input  logic [1:0]       id_pcsrc,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwr,
  input  logic             ex_memrd,
  input  logic             ex_branch_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwr,
  input  logic             mem_memrd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwr,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_j,
  output logic             irq_take,
  output logic             exc_take
);

  irq_state_e state_q;
  logic       irq_take_q;
  logic [1:0] stall_cnt_q, stall_cnt_d;

  logic       load_use, jr_dep, jr_ex_lw, jr_one;
  logic [1:0] cnt_eff;
  logic       stall_raw, flush_ifid_raw, flush_idex_raw, exc_raw, blocked;
  logic [1:0] fwd_a_raw, fwd_b_raw, fwd_j_raw;

  function automatic logic hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    load_use = ex_memrd && ((id_uses_rs && hit(id_rs, ex_rd)) ||
                            (id_uses_rt && hit(id_rt, ex_rd)));
    jr_dep   = (id_pcsrc == PC_JR) && id_uses_rs;
    jr_ex_lw = jr_dep && ex_memrd && hit(id_rs, ex_rd);
    jr_one   = jr_dep && ((ex_regwr && !ex_memrd && hit(id_rs, ex_rd)) ||
                          (mem_memrd && hit(id_rs, mem_rd)));

    // Counter holds stall cycles owed including the current one; a fresh
    // jr-behind-load starts it at 2 in the detection cycle itself.
    cnt_eff = (stall_cnt_q != 2'd0) ? stall_cnt_q : (jr_ex_lw ? 2'd2 : 2'd0);

    stall_raw      = !ex_branch_taken && (load_use || jr_one || (cnt_eff != 2'd0));
    stall_cnt_d    = (ex_branch_taken || (cnt_eff == 2'd0)) ? 2'd0 : cnt_eff - 2'd1;
    flush_ifid_raw = ex_branch_taken ||
                     (!stall_raw && ((id_pcsrc == PC_J) || (id_pcsrc == PC_JR)));
    flush_idex_raw = ex_branch_taken || stall_raw;
    exc_raw        = id_undef && !ex_branch_taken;
    blocked        = stall_raw || flush_ifid_raw || flush_idex_raw || exc_raw;
  end

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .src(ex_rs), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
    .wb_rd(wb_rd), .wb_regwr(wb_regwr), .sel(fwd_a_raw)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .src(ex_rt), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
    .wb_rd(wb_rd), .wb_regwr(wb_regwr), .sel(fwd_b_raw)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_j (
    .src(id_rs), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
    .wb_rd(wb_rd), .wb_regwr(wb_regwr), .sel(fwd_j_raw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 2'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IRQ_IDLE;
      irq_take_q <= 1'b0;
    end else begin
      irq_take_q <= 1'b0;
      case (state_q)
        IRQ_IDLE: begin
          if (irq && !kernel_mode) begin
            if (blocked) begin
              state_q <= IRQ_DEFER;
            end else begin
              state_q    <= IRQ_TAKE;
              irq_take_q <= 1'b1;
            end
          end
        end
        IRQ_DEFER: begin
          if (!irq) begin
            state_q <= IRQ_IDLE;
          end else if (!kernel_mode && !blocked) begin
            state_q    <= IRQ_TAKE;
            irq_take_q <= 1'b1;
          end
        end
        IRQ_TAKE:  state_q <= IRQ_ENTER;
        IRQ_ENTER: if (kernel_mode) state_q <= IRQ_RUN;
        IRQ_RUN:   if (!kernel_mode) state_q <= IRQ_IDLE;
        default:   state_q <= IRQ_IDLE;
      endcase
    end
  end

  // Reset is applied to the combinational outputs too, so the pipe sees no
  // stray stall or injection while the core is held.
  assign stall_pc   = reset && stall_raw;
  assign stall_ifid = reset && stall_raw;
  assign flush_ifid = reset && flush_ifid_raw;
  assign flush_idex = reset && flush_idex_raw;
  assign exc_take   = reset && exc_raw;
  assign irq_take   = reset && irq_take_q;
  assign fwd_a      = {2{reset}} & fwd_a_raw;
  assign fwd_b      = {2{reset}} & fwd_b_raw;
  assign fwd_j      = {2{reset}} & fwd_j_raw;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset, irq, kernel_mode, id_undef;
  logic [1:0] id_pcsrc;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, ex_regwr, ex_memrd, ex_branch_taken;
  logic       mem_regwr, mem_memrd, wb_regwr;
  logic       stall_pc, stall_ifid, flush_ifid, flush_idex, irq_take, exc_take;
  logic [1:0] fwd_a, fwd_b, fwd_j;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(5)) dut (
    .clk(clk), .reset(reset), .irq(irq), .kernel_mode(kernel_mode),
    .id_undef(id_undef), .id_pcsrc(id_pcsrc), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
    .mem_memrd(mem_memrd), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_j(fwd_j),
    .irq_take(irq_take), .exc_take(exc_take)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    irq = 1'b0; kernel_mode = 1'b0; id_undef = 1'b0; id_pcsrc = PC_SEQ;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_regwr = 1'b0; ex_memrd = 1'b0;
    ex_branch_taken = 1'b0; mem_rd = 5'd0; mem_regwr = 1'b0; mem_memrd = 1'b0;
    wb_rd = 5'd0; wb_regwr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jr9();
    id_pcsrc = PC_JR; id_rs = 5'd9; id_uses_rs = 1'b1;
  endtask

  task automatic ex_lw9();
    ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 5'd9;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held with every hazard/injection input active: outputs must stay 0.
    clr();
    reset = 1'b0;
    ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    id_undef = 1'b1; irq = 1'b1; ex_rs = 5'd8; mem_rd = 5'd8; mem_regwr = 1'b1;
    id_pcsrc = PC_J;
    #2;
    check("rst_stall_pc",   8'(stall_pc),   8'd0);
    check("rst_flush_ifid", 8'(flush_ifid), 8'd0);
    check("rst_flush_idex", 8'(flush_idex), 8'd0);
    check("rst_exc_take",   8'(exc_take),   8'd0);
    check("rst_fwd_a",      8'(fwd_a),      8'd0);
    check("rst_fwd_j",      8'(fwd_j),      8'd0);
    tick();
    tick();
    check("rst_irq_take", 8'(irq_take), 8'd0);
    check("rst_state", 8'(dut.state_q), 8'(IRQ_IDLE));
    clr();
    reset = 1'b1;
    tick();

    // Load-use on rs: one stall cycle, then the lw has moved to MEM.
    ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #2;
    check("lu_stall_pc",   8'(stall_pc),   8'd1);
    check("lu_stall_ifid", 8'(stall_ifid), 8'd1);
    check("lu_flush_idex", 8'(flush_idex), 8'd1);
    check("lu_flush_ifid", 8'(flush_ifid), 8'd0);
    tick();
    ex_memrd = 1'b0; ex_regwr = 1'b0; ex_rd = 5'd0;
    mem_rd = 5'd8; mem_regwr = 1'b1; mem_memrd = 1'b1;
    #2;
    check("lu_released", 8'(stall_pc), 8'd0);
    tick();
    clr();
    ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #2;
    check("lu_r0_nostall", 8'(stall_pc), 8'd0);
    ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1; id_rs = 5'd3;
    #2;
    check("lu_rt_stall", 8'(stall_ifid), 8'd1);
    id_uses_rt = 1'b0;
    #2;
    check("lu_rt_unused", 8'(stall_ifid), 8'd0);
    tick();

    // jr $9 behind lw $9: two stall cycles (second one from the counter alone).
    clr(); jr9(); ex_lw9();
    #2;
    check("jrlw_c1_stall", 8'(stall_pc),   8'd1);
    check("jrlw_c1_fifd",  8'(flush_ifid), 8'd0);
    check("jrlw_c1_fidex", 8'(flush_idex), 8'd1);
    tick();
    check("jrlw_cnt1", 8'(dut.stall_cnt_q), 8'd1);
    clr(); jr9();
    #2;
    check("jrlw_c2_stall", 8'(stall_pc),   8'd1);
    check("jrlw_c2_fifd",  8'(flush_ifid), 8'd0);
    tick();
    clr(); jr9(); wb_rd = 5'd9; wb_regwr = 1'b1;
    #2;
    check("jrlw_c3_stall", 8'(stall_pc),   8'd0);
    check("jrlw_c3_fifd",  8'(flush_ifid), 8'd1);
    check("jrlw_c3_fidex", 8'(flush_idex), 8'd0);
    check("jrlw_c3_fwdj",  8'(fwd_j),      8'd2);
    tick();

    // jr with MEM ALU producer: forwarded, no stall.
    clr(); jr9(); mem_rd = 5'd9; mem_regwr = 1'b1;
    #2;
    check("jrmem_stall", 8'(stall_pc),   8'd0);
    check("jrmem_fwdj",  8'(fwd_j),      8'd1);
    check("jrmem_fifd",  8'(flush_ifid), 8'd1);
    // jr with EX ALU producer: single stall, no counter.
    clr(); jr9(); ex_regwr = 1'b1; ex_rd = 5'd9;
    #2;
    check("jralu_stall", 8'(stall_pc), 8'd1);
    tick();
    clr(); jr9();
    #2;
    check("jralu_done", 8'(stall_pc), 8'd0);
    // jr with MEM lw producer: single stall.
    mem_rd = 5'd9; mem_regwr = 1'b1; mem_memrd = 1'b1;
    #2;
    check("jrmemlw_stall", 8'(stall_pc), 8'd1);
    tick();

    // EX operand forwarding priority.
    clr(); ex_rs = 5'd4; mem_rd = 5'd4; wb_rd = 5'd4; mem_regwr = 1'b1; wb_regwr = 1'b1;
    #2;
    check("fwda_mem", 8'(fwd_a), 8'd1);
    mem_regwr = 1'b0;
    #2;
    check("fwda_wb", 8'(fwd_a), 8'd2);
    ex_rt = 5'd4; ex_rs = 5'd5; mem_regwr = 1'b1;
    #2;
    check("fwdb_mem", 8'(fwd_b), 8'd1);
    check("fwda_none", 8'(fwd_a), 8'd0);
    mem_rd = 5'd0; wb_regwr = 1'b0;
    #2;
    check("fwdb_rf", 8'(fwd_b), 8'd0);
    clr(); mem_rd = 5'd0; mem_regwr = 1'b1;
    #2;
    check("fwda_r0", 8'(fwd_a), 8'd0);
    tick();

    // Jump flush, and jump losing to a concurrent load-use stall.
    clr(); id_pcsrc = PC_J;
    #2;
    check("j_flush", 8'(flush_ifid), 8'd1);
    check("j_nostall", 8'(stall_pc), 8'd0);
    ex_memrd = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #2;
    check("jlu_stall", 8'(stall_pc), 8'd1);
    check("jlu_noflush", 8'(flush_ifid), 8'd0);
    tick();

    // Branch taken overrides load-use and a counting jr stall.
    clr(); ex_memrd = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    ex_branch_taken = 1'b1; id_undef = 1'b1;
    #2;
    check("br_stall_pc",   8'(stall_pc),   8'd0);
    check("br_stall_ifid", 8'(stall_ifid), 8'd0);
    check("br_flush_ifid", 8'(flush_ifid), 8'd1);
    check("br_flush_idex", 8'(flush_idex), 8'd1);
    check("br_exc_masked", 8'(exc_take),   8'd0);
    tick();
    clr(); jr9(); ex_lw9();
    tick();
    check("brcnt_pre", 8'(dut.stall_cnt_q), 8'd1);
    clr(); jr9(); ex_branch_taken = 1'b1;
    #2;
    check("brcnt_stall", 8'(stall_pc), 8'd0);
    tick();
    check("brcnt_zero", 8'(dut.stall_cnt_q), 8'd0);
    clr(); jr9();
    #2;
    check("brcnt_after", 8'(stall_pc), 8'd0);
    check("brcnt_fifd", 8'(flush_ifid), 8'd1);
    tick();

    // Interrupt deferred by a jump flush, then taken, entered, run, exited.
    clr(); id_pcsrc = PC_J; irq = 1'b1;
    #2;
    check("irq_j_flush", 8'(flush_ifid), 8'd1);
    tick();
    id_pcsrc = PC_SEQ;
    #2;
    check("irq_defer", 8'(dut.state_q), 8'(IRQ_DEFER));
    check("irq_defer_strb", 8'(irq_take), 8'd0);
    tick();
    check("irq_take1", 8'(irq_take), 8'd1);
    check("irq_st_take", 8'(dut.state_q), 8'(IRQ_TAKE));
    tick();
    check("irq_take_w1", 8'(irq_take), 8'd0);
    check("irq_st_enter", 8'(dut.state_q), 8'(IRQ_ENTER));
    kernel_mode = 1'b1;
    tick();
    check("irq_st_run", 8'(dut.state_q), 8'(IRQ_RUN));
    tick();
    check("irq_run_nostrb", 8'(irq_take), 8'd0);
    kernel_mode = 1'b0;
    tick();
    check("irq_st_idle", 8'(dut.state_q), 8'(IRQ_IDLE));
    check("irq_idle_nostrb", 8'(irq_take), 8'd0);
    tick();
    check("irq_take2", 8'(irq_take), 8'd1);
    tick();
    check("irq_take2_w1", 8'(irq_take), 8'd0);
    kernel_mode = 1'b1;
    tick();
    kernel_mode = 1'b0; irq = 1'b0;
    tick();
    check("irq_back_idle", 8'(dut.state_q), 8'(IRQ_IDLE));

    // DEFER abandoned when irq drops.
    clr(); irq = 1'b1; ex_memrd = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    tick();
    check("dfr_enter", 8'(dut.state_q), 8'(IRQ_DEFER));
    clr();
    tick();
    check("dfr_drop", 8'(dut.state_q), 8'(IRQ_IDLE));

    // Exception beats a same-cycle interrupt acceptance.
    clr(); id_undef = 1'b1; irq = 1'b1;
    #2;
    check("exc_take", 8'(exc_take), 8'd1);
    tick();
    check("exc_defer", 8'(dut.state_q), 8'(IRQ_DEFER));
    check("exc_noirq", 8'(irq_take), 8'd0);
    id_undef = 1'b0;
    tick();
    check("exc_then_take", 8'(irq_take), 8'd1);
    tick();
    kernel_mode = 1'b1;
    tick();
    check("exc_run", 8'(dut.state_q), 8'(IRQ_RUN));

    // Reset pulse mid-RUN.
    ex_memrd = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; id_undef = 1'b1;
    reset = 1'b0;
    #1;
    check("rstrun_state", 8'(dut.state_q), 8'(IRQ_IDLE));
    check("rstrun_stall", 8'(stall_pc), 8'd0);
    check("rstrun_exc",   8'(exc_take), 8'd0);
    clr();
    reset = 1'b1;
    tick();

    // Reset mid-stall: counter cleared, no stall resumes.
    clr(); jr9(); ex_lw9();
    tick();
    clr(); jr9();
    reset = 1'b0;
    #1;
    check("rststall_cnt", 8'(dut.stall_cnt_q), 8'd0);
    reset = 1'b1;
    #1;
    check("rststall_none", 8'(stall_pc), 8'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the five-stage MIPS pipeline. It sits beside the ID- and IF-stage control decoders and drives the pipeline-register enables and flushes, the operand-forwarding selects, and the interrupt/exception injection strobes that feed the decoders' `Interrupt`/`Exception` inputs. It resolves load-use and jr/jalr register hazards, branch/jump redirects, and the entry/exit handshake for external interrupts.

## Interface
- `REG_W`, 5: register-specifier width.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `irq` in 1: external interrupt request, level.
- `kernel_mode` in 1: PC[31] of the instruction in ID; 1 masks `irq`.
- `id_undef` in 1: the ID decoder found an unknown opcode/funct.
- `id_pcsrc` in 2: PCSrc of the ID instruction. 00 = sequential, 01 = branch, 10 = j/jal, 11 = jr/jalr.
- `id_rs`, `id_rt` in REG_W: source registers of the ID instruction.
- `id_uses_rs`, `id_uses_rt` in 1: the ID instruction reads that operand.
- `ex_rs`, `ex_rt` in REG_W: source registers of the EX instruction.
- `ex_rd` in REG_W, `ex_regwr` in 1, `ex_memrd` in 1: destination and write/load flags of the EX instruction.
- `ex_branch_taken` in 1: the branch in EX resolved as taken.
- `mem_rd` in REG_W, `mem_regwr` in 1, `mem_memrd` in 1: destination and flags of the MEM instruction.
- `wb_rd` in REG_W, `wb_regwr` in 1: destination and write flag of the WB instruction.
- `stall_pc`, `stall_ifid` out 1: hold the PC and the IF/ID register.
- `flush_ifid`, `flush_idex` out 1: zero the pipeline register (bubble).
- `fwd_a`, `fwd_b` out 2: EX operand source. 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
- `fwd_j` out 2: ID-stage jr/jalr rs source, same encoding.
- `irq_take`, `exc_take` out 1: injection strobes to the IF/ID control decoders.

## Operation
- Register 0 never matches for hazard or forwarding purposes.
- **Load-use hazard:** `ex_memrd` && `ex_rd` matches a used ID source.
  - Assert `stall_pc`, `stall_ifid` and `flush_idex` for 1 cycle.
- **jr/jalr hazard** (`id_pcsrc`=11, rs used in ID):
  - EX lw producer: 2-cycle stall, tracked by a 2-bit stall counter.
  - EX ALU producer or MEM lw producer: 1-cycle stall.
  - MEM ALU producer: no stall; `fwd_j`=01.
  - WB producer: no stall; `fwd_j`=10.
  - After the stall clears, assert `flush_ifid` (the redirect squashes the fetched slot).
- **Jump** (`id_pcsrc`=10): `flush_ifid`.
- **Branch taken in EX:** `flush_ifid` and `flush_idex`.
  - This overrides any concurrent stall: stall outputs go to 0 and the stall counter clears.
- **Forwarding:**
  - `fwd_a` = 01 if `mem_regwr` && `mem_rd`==`ex_rs`; else 10 if `wb_regwr` && `wb_rd`==`ex_rs`; else 00.
  - `fwd_b` follows the same rule using `ex_rt`.
  - MEM has priority over WB.
- **Exception:**
  - `exc_take` = `id_undef` && !`ex_branch_taken`, combinational.
  - Exception has priority over interrupt: an interrupt acceptance in the same cycle is deferred.
- **Interrupt FSM** (states IDLE, DEFER, TAKE, ENTER, RUN):
  - IDLE→TAKE: `irq` && !`kernel_mode` && no stall && no flush && no `exc_take`.
  - IDLE→DEFER: `irq` && !`kernel_mode`, but blocked by a stall, a flush or an exception.
  - DEFER→TAKE: first unblocked cycle.
  - DEFER→IDLE: `irq` drops.
  - TAKE→ENTER: unconditional. `irq_take`=1 only in TAKE.
  - ENTER→RUN: `kernel_mode`=1.
  - RUN→IDLE: `kernel_mode`=0 (eret completed).
  - While in ENTER or RUN, `irq` is ignored.

## Timing
- Stall, flush, forward and `exc_take` outputs are combinational, valid in the same cycle as their inputs.
- `irq_take` is registered: asserted the cycle after the acceptance condition, width exactly 1 cycle.
- While `reset`=0:
  - FSM = IDLE and stall counter = 0.
  - All outputs forced to 0: `irq_take`=0, `exc_take`=0, `fwd_*`=00, all stalls/flushes 0.
- Reset deassertion mid-stall: no stall resumes; the counter is already 0.
- Stall counter: 2→1→0 on consecutive cycles with no wrap. A flush at any count forces it to 0 on the next edge.
- `irq` asserted during TAKE has no effect; `irq` held high into RUN produces no second strobe until the FSM returns to IDLE.
- Simultaneous load-use and jump in ID: the stall wins and `flush_ifid` waits until the stall clears.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - PCSrc encodings (PC_SEQ, PC_BR, PC_J, PC_JR).
  - Forward encodings (FWD_RF, FWD_MEM, FWD_WB).
  - The interrupt-FSM state enum.
- One sub-module, `fwd_select`: the rd/regwr priority comparator, instantiated three times (`fwd_a`, `fwd_b`, `fwd_j`).

## Test plan
- lw $8 in EX, ID uses rs=$8 → stall_pc/stall_ifid/flush_idex=1 for exactly 1 cycle. The same case with rs=$0 → no stall.
- jr $9 in ID with lw $9 in EX → 2 stall cycles, then flush_ifid=1; with mem_rd=$9 ALU producer → 0 stalls, fwd_j=01.
- mem_rd=wb_rd=ex_rs=$4, both regwr → fwd_a=01. Drop mem_regwr → fwd_a=10.
- Load-use stall while ex_branch_taken=1 → stalls 0, flush_ifid=flush_idex=1, counter 0 next cycle.
- Interrupt deferral and exit:
  - irq=1, kernel_mode=0 during a jump flush → DEFER.
  - Next clean cycle → TAKE, then irq_take pulses 1 cycle.
  - kernel_mode 1 → ENTER→RUN, then kernel_mode 0 → IDLE.
  - irq held high throughout produces no second pulse until IDLE.
- id_undef=1 and irq acceptance in the same cycle → exc_take=1, irq_take=0, FSM to DEFER. Reset pulse mid-RUN → IDLE, all outputs 0.
